prbs_pattern_checker: RTL and testbench

Serial receive-side checker that sits directly downstream of the PRBS-15 generator and consumes its one-bit-per-clock output. It hunts for the 32-bit preamble pattern, confirms that the pattern is repeated `n` times, then seeds a local PRBS-15 reference and counts bit errors on the pseudo-random payload. Its status and error count feed the bring-up/debug registers.

---
 rtl/prbs_pkg.sv | 25 ++
 rtl/prbs15_ref_lfsr.sv | 28 ++
 rtl/prbs_pattern_checker.sv | 160 ++++++++++++++++
 tb/tb_prbs_pattern_checker.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared constants, state encoding and next-bit helper for the
// PRBS-15 pattern checker and its reference LFSR.
package prbs_pkg;

  localparam int LFSR_W  = 15;
  localparam int FRAME_W = 32;
  localparam int TAP_HI  = 14;
  localparam int TAP_LO  = 13;

  localparam logic [FRAME_W-1:0] DEF_PATTERN = 32'hFFEEDDCC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_PATTERN,
    S_SEED,
    S_CHECK
  } state_t;

  // x^15 + x^14 + 1, oldest bit in the top position
  function automatic logic prbs_next(input logic [LFSR_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs15_ref_lfsr.sv
// PRBS-15 reference sequence: serial load from the line, free-running
// shift on its own output, and the predicted next bit.
module prbs15_ref_lfsr
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic din,
  output logic predict
);

  logic [LFSR_W-1:0] lfsr;

  assign predict = prbs_next(lfsr);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= {lfsr[LFSR_W-2:0], din};
    end else if (shift) begin
      lfsr <= {lfsr[LFSR_W-2:0], predict};
    end
  end

endmodule

// File: rtl/prbs_pattern_checker.sv
// Preamble hunter and PRBS-15 payload bit-error checker fed one bit
// per valid cycle by the PRBS generator.
module prbs_pattern_checker
  import prbs_pkg::*;
#(
  parameter logic [FRAME_W-1:0] PATTERN     = DEF_PATTERN,
  parameter int                 ERR_W       = 16,
  parameter int                 RELOCK_ERRS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_valid,
  input  logic             data_in,
  input  logic [2:0]       n,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             pattern_done,
  output logic             prbs_lock,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [2:0]       RELOCK = 3'(RELOCK_ERRS);
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] sr_nx;
  logic [4:0]         bcnt;
  logic [2:0]         fcnt;
  logic [2:0]         fcnt_nx;
  logic [2:0]         n_q;
  logic [2:0]         blk_err;
  logic [2:0]         blk_nx;
  logic               predict;
  logic               lfsr_load;
  logic               lfsr_shift;
  logic               miss;

  assign sr_nx      = {data_in, sr[FRAME_W-1:1]};
  assign fcnt_nx    = fcnt + 3'd1;
  assign miss       = data_in != predict;
  assign blk_nx     = blk_err + {2'b00, miss};
  assign lfsr_load  = en && bit_valid && (state == S_SEED);
  assign lfsr_shift = en && bit_valid && (state == S_CHECK);

  prbs15_ref_lfsr u_ref (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .shift   (lfsr_shift),
    .din     (data_in),
    .predict (predict)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sr           <= '0;
      bcnt         <= '0;
      fcnt         <= '0;
      n_q          <= '0;
      blk_err      <= '0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      pattern_done <= 1'b0;
      prbs_lock    <= 1'b0;
      bit_err      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      bit_err   <= 1'b0;
      if (bit_valid) sr <= sr_nx;
      if (!en) begin
        state        <= S_IDLE;
        fcnt         <= '0;
        bcnt         <= '0;
        blk_err      <= '0;
        pattern_done <= 1'b0;
        prbs_lock    <= 1'b0;
      end else if (bit_valid) begin
        unique case (state)
          S_IDLE: begin
            n_q  <= n;
            bcnt <= '0;
            fcnt <= '0;
            if (n == 3'd0) begin
              state        <= S_SEED;
              pattern_done <= 1'b1;
            end else begin
              state <= S_HUNT;
            end
          end
          S_HUNT: begin
            if (sr_nx == PATTERN) begin
              frame_ok <= 1'b1;
              fcnt     <= 3'd1;
              bcnt     <= '0;
              if (n_q == 3'd1) begin
                state        <= S_SEED;
                pattern_done <= 1'b1;
              end else begin
                state <= S_PATTERN;
              end
            end
          end
          S_PATTERN: begin
            bcnt <= bcnt + 5'd1;
            if (bcnt == 5'd31) begin
              bcnt <= '0;
              if (sr_nx == PATTERN) begin
                frame_ok <= 1'b1;
                fcnt     <= fcnt_nx;
                if (fcnt_nx == n_q) begin
                  state        <= S_SEED;
                  pattern_done <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                fcnt      <= '0;
                state     <= S_HUNT;
              end
            end
          end
          S_SEED: begin
            bcnt <= bcnt + 5'd1;
            if (bcnt == 5'd14) begin
              bcnt      <= '0;
              blk_err   <= '0;
              prbs_lock <= 1'b1;
              state     <= S_CHECK;
            end
          end
          S_CHECK: begin
            bcnt <= bcnt + 5'd1;
            if (miss) begin
              bit_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
            end
            // too many hits in one block means we lost alignment
            if (blk_nx == RELOCK) begin
              prbs_lock <= 1'b0;
              blk_err   <= '0;
              bcnt      <= '0;
              state     <= S_SEED;
            end else if (bcnt == 5'd31) begin
              blk_err <= '0;
            end else begin
              blk_err <= blk_nx;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_pattern_checker.sv
// Scoreboard bench: stimulus queues expected pulses by bit index,
// a negedge monitor pops and compares them as the DUT pulses.
module tb_prbs_pattern_checker;

  localparam logic [31:0] PAT = 32'hFFEEDDCC;
  localparam logic [31:0] BAD = 32'hFFEFDDCC;
  localparam int K_OK  = 1;
  localparam int K_ERR = 2;
  localparam int K_BIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        bit_valid;
  logic        data_in;
  logic [2:0]  n;
  logic        frame_ok;
  logic        frame_err;
  logic        pattern_done;
  logic        prbs_lock;
  logic        bit_err;
  logic [15:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int flips[$];
  bit pq[$];
  int next_idx = 0;
  int cur_idx  = 0;
  int smp_idx  = 0;
  int pidx     = 0;

  always #5 clk = ~clk;

  prbs_pattern_checker dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bit_valid    (bit_valid),
    .data_in      (data_in),
    .n            (n),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .pattern_done (pattern_done),
    .prbs_lock    (prbs_lock),
    .bit_err      (bit_err),
    .err_cnt      (err_cnt)
  );

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // index of the bit the DUT consumed at this edge
  always @(posedge clk) if (bit_valid) smp_idx <= cur_idx;

  task automatic pop_ev(int kind);
    int got;
    int e;
    got = kind * 100000 + smp_idx;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL pulse: kind %0d at bit %0d, none expected", kind, smp_idx);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        fails++;
        $display("FAIL pulse: got kind %0d bit %0d want kind %0d bit %0d",
                 kind, smp_idx, e / 100000, e % 100000);
      end
    end
  endtask

  always @(negedge clk) begin
    if (frame_ok)  pop_ev(K_OK);
    if (frame_err) pop_ev(K_ERR);
    if (bit_err)   pop_ev(K_BIT);
  end

  task automatic drive(logic b, logic v);
    @(posedge clk);
    #1;
    data_in   = b;
    bit_valid = v;
    if (v) begin
      cur_idx = next_idx;
      next_idx++;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0);
  endtask

  task automatic expect_ev(int kind);
    exp_q.push_back(kind * 100000 + next_idx);
  endtask

  task automatic send_word(logic [31:0] w, int kind);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) expect_ev(kind);
      drive(w[i], 1'b1);
    end
  endtask

  // b[k] = b[k-15] ^ b[k-14], started from a random nonzero fill
  task automatic gen_bit(output logic b);
    if (pq.size() == 0) b = 1'b1;
    else if (pq.size() < 15) b = 1'($urandom_range(0, 1));
    else b = pq[pq.size()-15] ^ pq[pq.size()-14];
    pq.push_back(b);
  endtask

  task automatic payload(int cnt, bit gap);
    logic b;
    bit   hit;
    for (int k = 0; k < cnt; k++) begin
      gen_bit(b);
      hit = 0;
      foreach (flips[j]) if (flips[j] == pidx) hit = 1;
      if (hit) begin
        b = ~b;
        expect_ev(K_BIT);
      end
      drive(b, 1'b1);
      pidx++;
      if (gap) idle();
    end
  endtask

  task automatic settle();
    idle();
    @(negedge clk);
  endtask

  task automatic start(logic [2:0] nv);
    @(posedge clk);
    #1;
    rst = 1; en = 0; bit_valid = 0; data_in = 0; n = nv;
    @(posedge clk);
    #1;
    rst = 0; en = 1;
    pq.delete();
    flips.delete();
    pidx = 0;
    drive(1'b0, 1'b1);
  endtask

  task automatic preamble2();
    send_word(PAT, K_OK);
    send_word(PAT, K_OK);
  endtask

  task automatic all_zero(string tag);
    check({tag, " frame_ok"}, frame_ok, 0);
    check({tag, " frame_err"}, frame_err, 0);
    check({tag, " pattern_done"}, pattern_done, 0);
    check({tag, " prbs_lock"}, prbs_lock, 0);
    check({tag, " bit_err"}, bit_err, 0);
    check({tag, " err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; en = 0; bit_valid = 0; data_in = 0; n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_zero("reset");

    // clean n=2 run
    start(3'd2);
    preamble2();
    settle();
    check("s1 pattern_done", pattern_done, 1);
    check("s1 lock early", prbs_lock, 0);
    payload(14, 0);
    settle();
    check("s1 lock at 14", prbs_lock, 0);
    payload(1, 0);
    settle();
    check("s1 lock at 15", prbs_lock, 1);
    payload(985, 0);
    settle();
    check("s1 err_cnt", err_cnt, 0);
    check("s1 lock held", prbs_lock, 1);
    check("s1 drained", exp_q.size(), 0);

    // corrupted second frame, then a good pair
    start(3'd2);
    send_word(PAT, K_OK);
    send_word(BAD, K_ERR);
    settle();
    check("s2 pattern_done low", pattern_done, 0);
    check("s2 lock low", prbs_lock, 0);
    preamble2();
    settle();
    check("s2 pattern_done", pattern_done, 1);
    payload(100, 0);
    settle();
    check("s2 lock", prbs_lock, 1);
    check("s2 err_cnt", err_cnt, 0);
    check("s2 drained", exp_q.size(), 0);

    // single flip
    start(3'd2);
    preamble2();
    flips.push_back(200);
    payload(1000, 0);
    settle();
    check("s3 err_cnt", err_cnt, 1);
    check("s3 lock", prbs_lock, 1);
    check("s3 drained", exp_q.size(), 0);

    // four flips in one block force a reseed
    start(3'd2);
    preamble2();
    flips.push_back(175);
    flips.push_back(180);
    flips.push_back(185);
    flips.push_back(190);
    payload(191, 0);
    settle();
    check("s4 err_cnt", err_cnt, 4);
    check("s4 lock dropped", prbs_lock, 0);
    payload(14, 0);
    settle();
    check("s4 relock at 14", prbs_lock, 0);
    payload(1, 0);
    settle();
    check("s4 relock at 15", prbs_lock, 1);
    payload(300, 0);
    settle();
    check("s4 err_cnt final", err_cnt, 4);
    check("s4 lock final", prbs_lock, 1);
    check("s4 drained", exp_q.size(), 0);

    // n=0, alternating valid
    start(3'd0);
    payload(14, 1);
    @(negedge clk);
    check("s5 lock at 14", prbs_lock, 0);
    flips.push_back(50);
    flips.push_back(120);
    payload(1, 1);
    @(negedge clk);
    check("s5 lock at 15", prbs_lock, 1);
    payload(200, 1);
    @(negedge clk);
    check("s5 err_cnt", err_cnt, 2);
    check("s5 drained", exp_q.size(), 0);

    // reset while locked with three errors
    start(3'd2);
    preamble2();
    flips.push_back(100);
    flips.push_back(101);
    flips.push_back(102);
    payload(300, 0);
    settle();
    check("s6 err_cnt", err_cnt, 3);
    check("s6 lock", prbs_lock, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    all_zero("s6 rst");
    check("s6 drained", exp_q.size(), 0);

    // en low only: err_cnt is kept
    start(3'd2);
    preamble2();
    flips.push_back(100);
    flips.push_back(101);
    flips.push_back(102);
    payload(300, 0);
    settle();
    check("s7 err_cnt", err_cnt, 3);
    @(posedge clk);
    #1;
    en = 0;
    @(posedge clk);
    @(negedge clk);
    check("s7 en-low lock", prbs_lock, 0);
    check("s7 en-low done", pattern_done, 0);
    check("s7 en-low err_cnt", err_cnt, 3);
    @(posedge clk);
    #1;
    en = 1;
    pq.delete();
    flips.delete();
    pidx = 0;
    drive(1'b0, 1'b1);
    preamble2();
    payload(100, 0);
    settle();
    check("s7 relock", prbs_lock, 1);
    check("s7 err_cnt kept", err_cnt, 3);
    check("s7 drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
